// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct codes,
// FSM state encoding and small decode helpers.
package muldiv_pkg;

  localparam int unsigned FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // True for the four multi-cycle arithmetic operations
  function automatic logic is_muldiv_op(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  // True for operations that treat operands as two's complement
  function automatic logic is_signed_op(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_DIV);
  endfunction

  // True for the two divide operations
  function automatic logic is_div_op(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation. Used both as absolute value on the
// operands (neg = sign bit) and as sign correction on the results.
module muldiv_signfix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result_c
);

  // Negate when requested, otherwise pass through
  assign result_c = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, both on operand
// magnitudes with sign correction applied in FIX.
// Optional feature: define MULDIV_EARLY_OUT_EN to let multiplies leave RUN as
// soon as the remaining multiplier bits are all zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   rd_data,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc: product (mult) or partial remainder in the low half (div)
  logic [W2-1:0]    acc_q, acc_d;
  // mcand: left-shifting multiplicand (mult) or divisor in the low half (div)
  logic [W2-1:0]    mcand_q, mcand_d;
  // mplier: right-shifting multiplier (mult) or dividend->quotient (div)
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;

  logic             ready_d, busy_d, done_d, err_d;
  logic [WIDTH-1:0] rd_data_d, hi_d, lo_d;

  logic             signed_op_c, div_op_c;
  logic             a_neg_c, b_neg_c;
  logic [WIDTH-1:0] abs_a_c, abs_b_c;
  logic [W2-1:0]    prod_fix_c;
  logic [WIDTH-1:0] quo_fix_c, rem_fix_c;
  logic [WIDTH:0]   div_trial_c;
  logic [WIDTH-1:0] div_diff_c;
  logic             div_ge_c;
  logic             run_exit_c;

  // Operand decode
  assign signed_op_c = is_signed_op(funct);
  assign div_op_c    = is_div_op(funct);
  assign a_neg_c     = signed_op_c & op_a[WIDTH-1];
  assign b_neg_c     = signed_op_c & op_b[WIDTH-1];

  muldiv_signfix #(.W(WIDTH)) u_abs_a (.value(op_a), .neg(a_neg_c), .result_c(abs_a_c));
  muldiv_signfix #(.W(WIDTH)) u_abs_b (.value(op_b), .neg(b_neg_c), .result_c(abs_b_c));

  muldiv_signfix #(.W(W2))    u_fix_prod (.value(acc_q),               .neg(neg_lo_q), .result_c(prod_fix_c));
  muldiv_signfix #(.W(WIDTH)) u_fix_quo  (.value(mplier_q),            .neg(neg_lo_q), .result_c(quo_fix_c));
  muldiv_signfix #(.W(WIDTH)) u_fix_rem  (.value(acc_q[WIDTH-1:0]),    .neg(neg_hi_q), .result_c(rem_fix_c));

  // Restoring-division trial subtract: shift in next dividend bit, compare to divisor
  assign div_trial_c = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
  assign div_ge_c    = div_trial_c >= {1'b0, mcand_q[WIDTH-1:0]};
  assign div_diff_c  = div_trial_c[WIDTH-1:0] - mcand_q[WIDTH-1:0];

  // RUN exit condition
`ifdef MULDIV_EARLY_OUT_EN
  assign run_exit_c = (cnt_q == CW'(0)) || (!is_div_q && (mplier_q == WIDTH'(0)));
`else
  assign run_exit_c = (cnt_q == CW'(0));
`endif

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_data_d = rd_data;
    hi_d      = hi;
    lo_d      = lo;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (funct == FUNCT_MFHI) begin
            rd_data_d = hi;
            done_d    = 1'b1;
          end else if (funct == FUNCT_MFLO) begin
            rd_data_d = lo;
            done_d    = 1'b1;
          end else if (is_muldiv_op(funct)) begin
            state_d  = RUN;
            cnt_d    = CW'(WIDTH - 1);
            acc_d    = W2'(0);
            is_div_d = div_op_c;
            if (div_op_c) begin
              mcand_d  = {WIDTH'(0), abs_b_c};
              mplier_d = abs_a_c;
              // Division by zero keeps the all-ones quotient unsigned
              neg_lo_d = (a_neg_c ^ b_neg_c) && (op_b != WIDTH'(0));
              neg_hi_d = a_neg_c;
            end else begin
              mcand_d  = {WIDTH'(0), abs_a_c};
              mplier_d = abs_b_c;
              neg_lo_d = a_neg_c ^ b_neg_c;
              neg_hi_d = 1'b0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (is_div_q) begin
          acc_d    = {WIDTH'(0), (div_ge_c ? div_diff_c : div_trial_c[WIDTH-1:0])};
          mplier_d = {mplier_q[WIDTH-2:0], div_ge_c};
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (run_exit_c) begin
          state_d = FIX;
          cnt_d   = CW'(0);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        state_d = DONE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix_c;
          lo_d = quo_fix_c;
        end else begin
          hi_d = prod_fix_c[W2-1:WIDTH];
          lo_d = prod_fix_c[WIDTH-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= CW'(0);
      acc_q    <= W2'(0);
      mcand_q  <= W2'(0);
      mplier_q <= WIDTH'(0);
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_data  <= WIDTH'(0);
      hi       <= WIDTH'(0);
      lo       <= WIDTH'(0);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      in_ready <= ready_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      rd_data  <= rd_data_d;
      hi       <= hi_d;
      lo       <= lo_d;
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS datapath, taking over the R-type funct codes the single-cycle ALU control cannot execute in one cycle (MULT, MULTU, DIV, DIVU, MFHI, MFLO). It owns the architectural HI/LO registers. It accepts one operation at a time through a valid/ready handshake and runs a WIDTH-cycle shift-add or restoring-division sequence. It signals completion with a one-cycle done pulse. It sits beside the ALU; the control unit stalls the pipe while busy is high.

## Interface
- WIDTH, 32, operand and HI/LO width (≥4)
- clk  in  1  rising-edge clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; high only in IDLE
- funct  in  6  R-type funct field of the requested operation
- op_a  in  WIDTH  rs value: multiplicand or dividend
- op_b  in  WIDTH  rt value: multiplier or divisor
- busy  out  1  high while an accepted operation is in progress
- done  out  1  one-cycle pulse when HI/LO or rd_data is updated
- err  out  1  one-cycle pulse for an unsupported funct
- rd_data  out  WIDTH  registered HI (MFHI) or LO (MFLO) value
- hi, lo  out  WIDTH  current architectural HI/LO

## Operation
- An operation is accepted on a clock edge where in_valid && in_ready; op_a, op_b and funct are captured. While busy, in_valid is ignored and nothing is queued.
- funct codes: 0x10 MFHI, 0x12 MFLO, 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU. Any other code is accepted, produces err one cycle later, and changes no state.
- FSM states:
  - IDLE: on accepting a MULT/MULTU/DIV/DIVU, go to RUN.
  - RUN: performs one step per cycle for WIDTH cycles, driven by a counter that counts down from WIDTH-1; when the counter reaches 0, go to FIX.
  - FIX: negates the quotient/remainder/product as required by the operand signs, then goes to DONE.
  - DONE: writes HI/LO, pulses done, returns to IDLE.
- MFHI/MFLO stay in IDLE: rd_data is loaded and done pulses on the next edge.
- Signed operations work on absolute values and are corrected in FIX:
  - product negated if the sign bits differ;
  - quotient negated if the sign bits differ;
  - remainder takes the dividend's sign.
- Results:
  - Multiply: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2·WIDTH product.
  - Divide: LO = quotient, HI = remainder.
- Division by zero: HI = op_a, LO = all ones, for both signed and unsigned. Still takes the full latency; no err.
- Signed overflow (most-negative / −1): LO = most-negative, HI = 0.
- rd_data holds its value until the next MFHI/MFLO.

## Timing
- Reset values: in_ready=1, busy=0, done=0, err=0, rd_data=0, hi=0, lo=0, FSM=IDLE, counter=0.
- Reset asserted mid-operation aborts the operation immediately. HI/LO return to 0 and no done is produced.
- Mult/div latency: the accept edge is cycle 0; RUN occupies cycles 1..WIDTH; FIX is cycle WIDTH+1; done is high and HI/LO are updated in cycle WIDTH+2.
- busy is high from cycle 1 through cycle WIDTH+2 inclusive. in_ready returns high in cycle WIDTH+3.
- MFHI/MFLO latency is 1: done and rd_data are valid in cycle 1. in_ready stays high, so back-to-back accepts are allowed.
- Unsupported funct: err is high in cycle 1; done stays low.
- done and err are never high in the same cycle.

## Configuration
- MULDIV_EARLY_OUT_EN
  - Defined: for MULT/MULTU, RUN exits to FIX as soon as the remaining multiplier bits are all zero. Latency becomes (index of highest set bit of |op_b|)+4 cycles, minimum 3 when op_b=0. Division is unaffected.
  - Undefined: fixed WIDTH+2 latency for every mult/div.

## Structure
- Shared package muldiv_pkg holds:
  - funct localparams (FUNCT_MFHI, FUNCT_MFLO, FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU);
  - the FSM state enum (IDLE, RUN, FIX, DONE).
- One natural sub-module: muldiv_signfix, a combinational block for absolute value on input and conditional two's-complement on output, instantiated for the operands and the results.

## Test plan
- MULT op_a=0xFFFFFFFD (−3), op_b=5 -> done in cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU op_a=0xFFFFFFFF, op_b=2 -> HI=0x00000001, LO=0xFFFFFFFE; then MFHI -> rd_data=1 with done one cycle later.
- DIV op_a=0xFFFFFFF9 (−7), op_b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU op_a=0x64, op_b=0 -> LO=0xFFFFFFFF, HI=0x64 after 34 cycles; err stays 0.
- in_valid held high with funct=0x18 during busy -> exactly one operation executes. Then funct=0x3F -> err pulse in cycle 1, HI/LO unchanged.
- rst_n driven low in cycle 10 of a DIV -> busy=0, in_ready=1, hi=lo=0, no done pulse. A new MULT 3×4 after release -> LO=12, HI=0.
